// File: rtl/hazard_forward_unit_if.sv
// rtl/hazard_forward_unit_if.sv - decode-side fields in, forwarding/stall/flush controls out
interface hazard_forward_unit_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       Rs1D;
  logic [4:0]       Rs2D;
  logic [4:0]       RdD;
  logic             RegWriteD;
  logic             ResultSrcD;
  logic             PCSrcE;
  logic [1:0]       ForwardAE;
  logic [1:0]       ForwardBE;
  logic             StallF;
  logic             StallD;
  logic             FlushD;
  logic             FlushE;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output Rs1D, Rs2D, RdD, RegWriteD, ResultSrcD, PCSrcE,
    input  ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE, stall_count, flush_count
  );

  modport slave (
    input  Rs1D, Rs2D, RdD, RegWriteD, ResultSrcD, PCSrcE,
    output ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE, stall_count, flush_count
  );
endinterface

// File: rtl/hazard_forward_unit.sv
// rtl/hazard_forward_unit.sv - shadow E/M/W scoreboard driving forwarding, load-use stall and branch flush
module hazard_forward_unit #(
  parameter int BRANCH_FLUSH_CYCLES = 2,
  parameter int CNT_W               = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  hazard_forward_unit_if.slave bus
);
  localparam int FC_W = (BRANCH_FLUSH_CYCLES > 1) ? $clog2(BRANCH_FLUSH_CYCLES) : 1;

  typedef enum logic {RUN, FLUSH} state_t;

  state_t           r_state;
  logic [FC_W-1:0]  r_fcnt;
  logic [4:0]       r_e_rs1;
  logic [4:0]       r_e_rs2;
  logic [4:0]       r_e_rd;
  logic             r_e_rw;
  logic             r_e_ld;
  logic [4:0]       r_m_rd;
  logic             r_m_rw;
  logic [4:0]       r_w_rd;
  logic             r_w_rw;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic       w_lw;
  logic       w_branch;
  logic       w_stall;
  logic       w_flush_e;
  logic [1:0] w_fwd_a;
  logic [1:0] w_fwd_b;

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic [4:0] m_rd,
                                         input logic m_rw, input logic [4:0] w_rd,
                                         input logic w_rw);
    if (m_rw && m_rd != 5'd0 && m_rd == rs)
      return 2'b01;
    if (w_rw && w_rd != 5'd0 && w_rd == rs)
      return 2'b10;
    return 2'b00;
  endfunction

  assign w_fwd_a = fwd_sel(r_e_rs1, r_m_rd, r_m_rw, r_w_rd, r_w_rw);
  assign w_fwd_b = fwd_sel(r_e_rs2, r_m_rd, r_m_rw, r_w_rd, r_w_rw);

  assign w_lw = r_e_ld && r_e_rw && (r_e_rd != 5'd0) &&
                ((r_e_rd == bus.Rs1D) || (r_e_rd == bus.Rs2D));

  // A branch discards the dependent instruction, so flush always beats stall.
  assign w_branch  = bus.PCSrcE || (r_state == FLUSH);
  assign w_stall   = !w_branch && w_lw;
  assign w_flush_e = w_branch || w_lw;

  assign bus.ForwardAE   = rst ? 2'b00 : w_fwd_a;
  assign bus.ForwardBE   = rst ? 2'b00 : w_fwd_b;
  assign bus.StallF      = !rst && w_stall;
  assign bus.StallD      = !rst && w_stall;
  assign bus.FlushD      = !rst && w_branch;
  assign bus.FlushE      = !rst && w_flush_e;
  assign bus.stall_count = r_stall_cnt;
  assign bus.flush_count = r_flush_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= RUN;
      r_fcnt      <= '0;
      r_e_rs1     <= '0;
      r_e_rs2     <= '0;
      r_e_rd      <= '0;
      r_e_rw      <= 1'b0;
      r_e_ld      <= 1'b0;
      r_m_rd      <= '0;
      r_m_rw      <= 1'b0;
      r_w_rd      <= '0;
      r_w_rw      <= 1'b0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_w_rd <= r_m_rd;
      r_w_rw <= r_m_rw;
      r_m_rd <= r_e_rd;
      r_m_rw <= r_e_rw;
      if (w_flush_e) begin
        r_e_rs1 <= '0;
        r_e_rs2 <= '0;
        r_e_rd  <= '0;
        r_e_rw  <= 1'b0;
        r_e_ld  <= 1'b0;
      end else begin
        r_e_rs1 <= bus.Rs1D;
        r_e_rs2 <= bus.Rs2D;
        r_e_rd  <= bus.RdD;
        r_e_rw  <= bus.RegWriteD;
        r_e_ld  <= bus.ResultSrcD;
      end

      // The PCSrcE cycle is the first flush cycle; FLUSH covers the remaining ones.
      if (bus.PCSrcE) begin
        r_fcnt  <= FC_W'(BRANCH_FLUSH_CYCLES - 1);
        r_state <= (BRANCH_FLUSH_CYCLES > 1) ? FLUSH : RUN;
      end else if (r_state == FLUSH) begin
        r_fcnt <= r_fcnt - 1'b1;
        if (r_fcnt == FC_W'(1))
          r_state <= RUN;
      end

      if (w_stall && r_stall_cnt != '1)
        r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_flush_e && !w_stall && r_flush_cnt != '1)
        r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end
endmodule
